ipc_keyscan: RTL and testbench

IPC_KEYSCAN -- requirements
Module: ipc_keyscan

---
 rtl/ipc_keyscan.sv | 163 ++++++++++++++++
 tb/tb_ipc_keyscan.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ipc_keyscan.sv
// ipc_keyscan: keyboard matrix scanner with key-event FIFO.
//
// One matrix key is examined per scan_en cycle. When a key's state differs
// from the last state reported for it, the scanner pushes a {press, code}
// event into a FIFO. If the FIFO is full, the event is held back and picked
// up again on the next pass, and the sticky overflow flag is set. A
// combinational column readout (col_data) is kept for legacy row/column
// polling.
//
// Optional feature: define IPC_KEYSCAN_DEBOUNCE_EN to compare against a
// matrix snapshot taken at idx 0 of each pass. A pass emits events only when
// its snapshot equals the snapshot of the previous pass.
//
// Ports:
//   clk11      in   system clock, rising edge
//   reset      in   asynchronous reset, active high
//   matrix     in   [KEYS]     live key state, bit r*COLS+c, 1 = pressed
//   row_sel    in   [ROWS]     legacy row select
//   col_data   out  [COLS]     OR of the selected matrix rows
//   scan_en    in              advance the scanner by one key
//   evt_valid  out             FIFO is not empty
//   evt_data   out  [CODE_W+1] {press, key code} at the FIFO head
//   evt_rd     in              pop request, ignored while empty
//   evt_count  out  [CNT_W]    FIFO occupancy
//   overflow   out             sticky: an event was held back on a full FIFO
//   ovf_clr    in              clears overflow; a same-cycle set wins
module ipc_keyscan #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int KEYS      = ROWS * COLS,
    localparam int CODE_W    = (KEYS > 1) ? $clog2(KEYS) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk11,
    input  logic              reset,
    input  logic [KEYS-1:0]   matrix,
    input  logic [ROWS-1:0]   row_sel,
    output logic [COLS-1:0]   col_data,
    input  logic              scan_en,
    output logic              evt_valid,
    output logic [CODE_W:0]   evt_data,
    input  logic              evt_rd,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overflow,
    input  logic              ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [KEYS-1:0]   reported;
    logic [CODE_W-1:0] idx;
    logic [CODE_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;

    logic src_bit;
    logic gen_ok;
    logic differ;
    logic full;
    logic pop;
    logic push;
    logic ovf_set;

    // Legacy readout always works from the live matrix.
    always_comb begin
        col_data = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_sel[r]) begin
                col_data = col_data | matrix[r*COLS +: COLS];
            end
        end
    end

`ifdef IPC_KEYSCAN_DEBOUNCE_EN
    logic [KEYS-1:0] snap;
    logic [KEYS-1:0] snap_prev;
    logic [KEYS-1:0] cur_src;
    logic [KEYS-1:0] prev_src;

    // At idx 0 the snapshot is being loaded this very cycle, so the compare
    // looks through to the value being latched; this keeps every key of a
    // pass judged against the same snapshot pair.
    always_comb begin
        cur_src  = snap;
        prev_src = snap_prev;
        if (idx == '0) begin
            cur_src  = matrix;
            prev_src = snap;
        end
        src_bit = cur_src[idx];
        gen_ok  = (cur_src == prev_src);
    end

    always_ff @(posedge clk11 or posedge reset) begin
        if (reset) begin
            snap      <= '0;
            snap_prev <= '0;
        end else if (scan_en && idx == '0) begin
            snap      <= matrix;
            snap_prev <= snap;
        end
    end
`else
    always_comb begin
        src_bit = matrix[idx];
        gen_ok  = 1'b1;
    end
`endif

    // A full FIFO still accepts a push when a pop retires an entry in the
    // same cycle.
    always_comb begin
        full    = (count == CNT_W'(FIFO_DEPTH));
        pop     = evt_rd && (count != '0);
        differ  = scan_en && gen_ok && (src_bit != reported[idx]);
        push    = differ && (!full || pop);
        ovf_set = differ && full && !pop;
    end

    always_ff @(posedge clk11 or posedge reset) begin
        if (reset) begin
            reported <= '0;
            idx      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (scan_en) begin
                idx <= (idx == CODE_W'(KEYS - 1)) ? '0 : idx + 1'b1;
            end
            if (push) begin
                reported[idx] <= src_bit;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk11) begin
        if (push) begin
            mem[wr_ptr] <= {src_bit, idx};
        end
    end

    assign evt_valid = (count != '0);
    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;
    assign evt_count = count;

endmodule

// File: tb/tb_ipc_keyscan.sv
// tb_ipc_keyscan: scoreboard bench for ipc_keyscan (8x8 matrix, 4-deep FIFO).
// Stimulus pushes expected events into a queue; a monitor pops and compares
// them whenever the DUT performs a pop. Status outputs are checked inline.
module tb_ipc_keyscan;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int DEPTH  = 4;
    localparam int KEYS   = 64;
    localparam int CODE_W = 6;
    localparam int CNT_W  = 3;

    logic              clk11 = 1'b0;
    logic              reset;
    logic [KEYS-1:0]   matrix;
    logic [ROWS-1:0]   row_sel;
    logic [COLS-1:0]   col_data;
    logic              scan_en;
    logic              evt_valid;
    logic [CODE_W:0]   evt_data;
    logic              evt_rd;
    logic [CNT_W-1:0]  evt_count;
    logic              overflow;
    logic              ovf_clr;

    int n_cmp = 0;
    int n_err = 0;
    logic [CODE_W:0] exp_q [$];

    ipc_keyscan #(.ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(DEPTH)) dut (
        .clk11(clk11), .reset(reset), .matrix(matrix), .row_sel(row_sel),
        .col_data(col_data), .scan_en(scan_en), .evt_valid(evt_valid),
        .evt_data(evt_data), .evt_rd(evt_rd), .evt_count(evt_count),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk11 = ~clk11;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge, so compare the head now.
    always @(negedge clk11) begin
        if (!reset && evt_valid && evt_rd) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL evt_unexpected: got 0x%0h expected none", evt_data);
            end else begin
                check("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cycle();
        @(posedge clk11);
        #1;
    endtask

    task automatic scan(input int n, input logic rd);
        for (int i = 0; i < n; i++) begin
            scan_en = 1'b1;
            evt_rd  = rd;
            cycle();
        end
        scan_en = 1'b0;
        evt_rd  = 1'b0;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            evt_rd = 1'b1;
            cycle();
        end
        evt_rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; matrix = '0; row_sel = '0; scan_en = 1'b0;
        evt_rd = 1'b0; ovf_clr = 1'b0;
        #12;
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_data", 32'(evt_data), 0);
        check("rst_count", 32'(evt_count), 0);
        check("rst_overflow", 32'(overflow), 0);
        cycle();
        reset = 1'b0;
        cycle();

        // Legacy column readout
        matrix[7:0] = 8'h11; matrix[23:16] = 8'h80; row_sel = 8'h05; #1;
        check("col_rows_0_2", 32'(col_data), 'h91);
        row_sel = 8'h04; #1;
        check("col_row_2", 32'(col_data), 'h80);
        row_sel = 8'h02; #1;
        check("col_row_1", 32'(col_data), 'h00);
        row_sel = 8'h00; #1;
        check("col_none", 32'(col_data), 'h00);
        matrix = '0;
        cycle();

        // Read while empty is ignored
        pop_n(2);
        check("empty_rd_count", 32'(evt_count), 0);
        check("empty_rd_valid", 32'(evt_valid), 0);

`ifdef IPC_KEYSCAN_DEBOUNCE_EN
        // Key 7 toggles every pass: never stable, no events
        for (int p = 0; p < 4; p++) begin
            matrix = '0;
            matrix[7] = (p % 2 == 0);
            scan(64, 1'b0);
        end
        check("db_toggle_count", 32'(evt_count), 0);
        matrix = '0; matrix[7] = 1'b1;
        scan(64, 1'b0);
        check("db_first_pass_count", 32'(evt_count), 0);
        exp_q.push_back(7'h47);
        scan(64, 1'b0);
        check("db_stable_count", 32'(evt_count), 1);
        pop_n(1);
        check("db_drained", 32'(evt_count), 0);
`else
        // Single press and release of key 10
        matrix[10] = 1'b1;
        exp_q.push_back(7'h4A);
        scan(64, 1'b0);
        check("press_count", 32'(evt_count), 1);
        check("press_valid", 32'(evt_valid), 1);
        check("press_data", 32'(evt_data), 'h4A);
        pop_n(1);
        check("press_popped", 32'(evt_count), 0);
        matrix[10] = 1'b0;
        exp_q.push_back(7'h0A);
        scan(64, 1'b0);
        check("release_count", 32'(evt_count), 1);
        pop_n(1);

        // Overflow: six presses into a 4-deep FIFO
        matrix = '0;
        matrix[1] = 1'b1; matrix[5] = 1'b1; matrix[20] = 1'b1;
        matrix[33] = 1'b1; matrix[40] = 1'b1; matrix[63] = 1'b1;
        exp_q.push_back(7'h41); exp_q.push_back(7'h45);
        exp_q.push_back(7'h54); exp_q.push_back(7'h61);
        scan(64, 1'b0);
        check("ovf_count", 32'(evt_count), 4);
        check("ovf_flag", 32'(overflow), 1);
        pop_n(4);
        check("ovf_drained", 32'(evt_count), 0);
        check("ovf_sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);
        exp_q.push_back(7'h68); exp_q.push_back(7'h7F);
        scan(64, 1'b0);
        check("retry_count", 32'(evt_count), 2);
        check("retry_no_ovf", 32'(overflow), 0);
        pop_n(2);

        // Full FIFO with push and pop in the same cycle (at idx 40)
        matrix = '0;
        exp_q.push_back(7'h01); exp_q.push_back(7'h05); exp_q.push_back(7'h14);
        exp_q.push_back(7'h21); exp_q.push_back(7'h28); exp_q.push_back(7'h3F);
        scan(40, 1'b0);
        check("full_count", 32'(evt_count), 4);
        scan(1, 1'b1);
        check("pushpop_count", 32'(evt_count), 4);
        check("pushpop_no_ovf", 32'(overflow), 0);
        pop_n(4);
        scan(23, 1'b0);
        check("tail_count", 32'(evt_count), 1);
        pop_n(1);

        // Reset in the middle of a pass with keys 3 and 63 held
        matrix = '0; matrix[3] = 1'b1; matrix[63] = 1'b1;
        scan(30, 1'b0);
        check("pre_reset_count", 32'(evt_count), 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_count", 32'(evt_count), 0);
        check("midrst_valid", 32'(evt_valid), 0);
        check("midrst_data", 32'(evt_data), 0);
        cycle();
        reset = 1'b0;
        exp_q.push_back(7'h43); exp_q.push_back(7'h7F);
        scan(65, 1'b0);
        check("post_reset_count", 32'(evt_count), 2);
        pop_n(2);
        check("post_reset_drained", 32'(evt_count), 0);
`endif

        cycle();
        cycle();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
